uart_transmitter: RTL and testbench

Serial UART transmitter that sends one 32-bit word as four consecutive 8N1 byte frames, least significant byte first, on a single TX line. It sits beside the data memory. The memory presents the word at its read pointer on dataIn, and advances that pointer on the rising edge of dataOver. If TxD_start is held high, the transmitter streams successive memory words back-to-back.

---
 rtl/uart_transmitter.sv | 129 ++++++++++++
 tb/tb_uart_transmitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: sends a latched 32-bit word as four byte frames, LSB byte first,
// pulsing dataOver after the last stop bit so the data memory can advance its read pointer.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        TxD_start,
    input  logic [31:0] dataIn,
    output logic        dataOver,
    output logic        dataOut
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [31:0]     word_q, word_d;
    logic            tx_q, tx_d;
    logic            over_q, over_d;
    logic            baud_done;

    assign baud_done = (baud_q == BaudMax);

    // The line value for the next cycle is decided here, so dataOut is a pure register output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        tx_d    = tx_q;
        over_d  = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (TxD_start) begin
                    word_d  = dataIn;
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    tx_d    = word_q[{byte_q, 3'd0}];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = word_q[{byte_q, bit_q + 3'd1}];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = StDone;
                        tx_d    = 1'b1;
                        over_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            word_q  <= 32'd0;
            tx_q    <= 1'b1;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            over_q  <= over_d;
        end
    end

    assign dataOut  = tx_q;
    assign dataOver = over_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor decodes frames and checks them against
// a queue of expected bytes pushed by the stimulus sequence.
module tb_uart_transmitter;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        rst;
    logic        TxD_start;
    logic [31:0] dataIn;
    logic        dataOver;
    logic        dataOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;
    exp_t sb[$];

    uart_transmitter #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .TxD_start(TxD_start),
        .dataIn   (dataIn),
        .dataOver (dataOver),
        .dataOut  (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int gap0);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.data = w[8*i +: 8];
            e.gap  = (i == 0) ? gap0 : 0;
            sb.push_back(e);
        end
    endtask

    // Returns the number of falling edges until dataOver is seen, or -1 on timeout.
    task automatic wait_over(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dataOver === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Line monitor: samples every falling edge, captures whole frames.
    int               mon_cnt    = -1;
    int               high_run   = 0;
    int               start_run  = 0;
    int               since_frame = 100;
    logic [FRAME-1:0] mon_s;

    always @(negedge clk) begin
        logic       shape_ok;
        logic [7:0] d;
        exp_t       e;
        since_frame++;
        if (rst === 1'b1 && dataOver === 1'b1) chk("dataover_timing", since_frame, 1);
        if (rst !== 1'b1) begin
            mon_cnt  = -1;
            high_run = 0;
        end else if (mon_cnt < 0) begin
            if (dataOut === 1'b0) begin
                mon_s[0]  = 1'b0;
                mon_cnt   = 1;
                start_run = high_run;
            end else begin
                high_run++;
            end
        end else begin
            mon_s[mon_cnt] = dataOut;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                shape_ok = 1'b1;
                for (int b = 0; b < 10; b++)
                    for (int k = 1; k < CPB; k++)
                        if (mon_s[b*CPB+k] !== mon_s[b*CPB]) shape_ok = 1'b0;
                if (mon_s[0] !== 1'b0 || mon_s[9*CPB] !== 1'b1) shape_ok = 1'b0;
                for (int i = 0; i < 8; i++) d[i] = mon_s[(i+1)*CPB];
                chk("frame_shape", {31'd0, shape_ok}, 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_frame", {24'd0, d}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("frame_byte", {24'd0, d}, {24'd0, e.data});
                    if (e.gap >= 0) chk("frame_gap", start_run, e.gap);
                end
                mon_cnt     = -1;
                high_run    = 0;
                since_frame = 0;
            end
        end
    end

    initial begin
        int   n;
        logic bad;
        rst       = 1'b0;
        TxD_start = 1'b0;
        dataIn    = 32'd0;

        // 1: reset values and idle line
        repeat (5) @(negedge clk);
        chk("reset_dataout", {31'd0, dataOut}, 32'd1);
        chk("reset_dataover", {31'd0, dataOver}, 32'd0);
        rst = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dataOut !== 1'b1 || dataOver !== 1'b0) bad = 1'b1;
        end
        chk("idle_after_reset", {31'd0, bad}, 32'd0);

        // 2: single word
        dataIn    = 32'hA55A_3C01;
        TxD_start = 1'b1;
        push_word(32'hA55A_3C01, -1);
        @(negedge clk);
        TxD_start = 1'b0;
        wait_over(400, n);
        chk("single_word_cycles", n, 160);
        @(negedge clk);
        chk("single_over_one_cycle", {31'd0, dataOver}, 32'd0);
        chk("single_queue_empty", sb.size(), 0);

        // 3: word latched at start
        repeat (5) @(negedge clk);
        dataIn    = 32'h0000_00FF;
        TxD_start = 1'b1;
        push_word(32'h0000_00FF, -1);
        @(negedge clk);
        TxD_start = 1'b0;
        repeat (10) @(negedge clk);
        dataIn = 32'h1234_5678;
        wait_over(400, n);
        chk("latch_word_cycles", n, 150);
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (dataOver !== 1'b0 || dataOut !== 1'b1) bad = 1'b1;
        end
        chk("latch_no_second_word", {31'd0, bad}, 32'd0);
        chk("latch_queue_empty", sb.size(), 0);

        // 4: streaming with memory pointer advanced by dataOver
        dataIn    = 32'd0;
        TxD_start = 1'b1;
        push_word(32'd0, -1);
        push_word(32'd1, 2);
        push_word(32'd2, 2);
        for (int w = 0; w < 3; w++) begin
            wait_over(400, n);
            chk("stream_word_cycles", n, (w == 0) ? 161 : 162);
            dataIn = dataIn + 32'd1;
            if (w == 2) TxD_start = 1'b0;
        end
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (dataOver !== 1'b0 || dataOut !== 1'b1) bad = 1'b1;
        end
        chk("stream_stops", {31'd0, bad}, 32'd0);
        chk("stream_queue_empty", sb.size(), 0);

        // 5: start pulse while busy is ignored
        dataIn    = 32'hC396_0FE7;
        TxD_start = 1'b1;
        push_word(32'hC396_0FE7, -1);
        @(negedge clk);
        TxD_start = 1'b0;
        repeat (49) @(negedge clk);
        dataIn    = 32'hDEAD_BEEF;
        TxD_start = 1'b1;
        @(negedge clk);
        TxD_start = 1'b0;
        wait_over(400, n);
        chk("busy_word_cycles", n, 110);
        bad = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (dataOver !== 1'b0 || dataOut !== 1'b1) bad = 1'b1;
        end
        chk("busy_no_restart", {31'd0, bad}, 32'd0);
        chk("busy_queue_empty", sb.size(), 0);

        // 6: asynchronous reset during byte 2 data bits
        dataIn    = 32'h00FF_5AA5;
        TxD_start = 1'b1;
        push_word(32'h00FF_5AA5, -1);
        void'(sb.pop_back());
        void'(sb.pop_back());
        @(negedge clk);
        TxD_start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_line_high", {31'd0, dataOut}, 32'd1);
        chk("abort_no_over", {31'd0, dataOver}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (dataOver !== 1'b0 || dataOut !== 1'b1) bad = 1'b1;
        end
        chk("abort_idle_after", {31'd0, bad}, 32'd0);
        chk("abort_queue_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
